// File: rtl/ff_bist_if.sv
// rtl/ff_bist_if.sv - control, status and flip-flop-side signals of the ff_bist controller
interface ff_bist_if #(
  parameter int ERR_W = 8,
  parameter int IW    = 5
);
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic             fail_valid;
  logic [IW-1:0]    fail_index;
  logic             dut_reset;
  logic             dut_d;
  logic             dut_q;
  logic             dut_qbar;

  modport master (
    input  start, dut_q, dut_qbar,
    output busy, done, pass, err_count, fail_valid, fail_index, dut_reset, dut_d
  );

  modport slave (
    output start, dut_q, dut_qbar,
    input  busy, done, pass, err_count, fail_valid, fail_index, dut_reset, dut_d
  );
endinterface

// File: rtl/ff_bist.sv
// rtl/ff_bist.sv - self-test controller that replays a bit pattern into a D flip-flop and checks Q/Qbar
module ff_bist #(
  parameter int                     PATTERN_LEN = 16,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 16'hB4C3,
  parameter int                     RST_CYCLES  = 2,
  parameter int                     ERR_W       = 8
) (
  input logic       clk,
  input logic       reset,
  ff_bist_if.master bus
);
  localparam int IW   = $clog2(PATTERN_LEN + 2);
  localparam int CMAX = (PATTERN_LEN > RST_CYCLES) ? PATTERN_LEN : RST_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(PATTERN_LEN - 1);

  typedef enum logic [2:0] {IDLE, RST, RUN, FLUSH, DONE} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [PATTERN_LEN:0] pat_sr;
  logic                 d_prev;
  logic                 dut_reset_q, dut_d_q;
  logic [ERR_W-1:0]     err_q;
  logic                 fail_valid_q;
  logic [IW-1:0]        fail_index_q;

  logic dut_reset_nxt, dut_d_nxt, clear, cmp_en, exp_bit, cmp_fail;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      pat_sr       <= {1'b0, PATTERN};
      d_prev       <= 1'b0;
      dut_reset_q  <= 1'b1;
      dut_d_q      <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_index_q <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || !((state == RST) || (state == RUN)))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
      pat_sr      <= (state == RUN) ? (pat_sr >> 1) : {1'b0, PATTERN};
      d_prev      <= dut_d_q;
      dut_reset_q <= dut_reset_nxt;
      dut_d_q     <= dut_d_nxt;
      if (clear) begin
        idx          <= '0;
        err_q        <= '0;
        fail_valid_q <= 1'b0;
        fail_index_q <= '0;
      end else if (cmp_en) begin
        idx <= idx + 1'b1;
        if (cmp_fail) begin
          if (err_q != {ERR_W{1'b1}})
            err_q <= err_q + 1'b1;
          if (!fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_index_q <= idx;
          end
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RST;
      RST:     if (cnt == RST_LAST) state_nxt = RUN;
      RUN:     if (cnt == RUN_LAST) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    if (bus.start) state_nxt = RST;
      default: state_nxt = IDLE;
    endcase
  end

  // The bit driven in the previous cycle is what a healthy flop presents on Q now;
  // the last RST cycle drives 0, which doubles as the post-reset expectation.
  always_comb begin
    clear         = ((state == IDLE) || (state == DONE)) && bus.start;
    cmp_en        = (state == RUN) || (state == FLUSH);
    exp_bit       = d_prev;
    cmp_fail      = cmp_en && ((bus.dut_q != exp_bit) || (bus.dut_qbar != ~exp_bit));
    dut_reset_nxt = (state_nxt == RST);
    dut_d_nxt     = 1'b0;
    if (state_nxt == RUN)
      dut_d_nxt = (state == RUN) ? pat_sr[1] : pat_sr[0];
  end

  assign bus.dut_reset  = dut_reset_q;
  assign bus.dut_d      = dut_d_q;
  assign bus.busy       = (state == RST) || (state == RUN) || (state == FLUSH);
  assign bus.done       = (state == DONE);
  assign bus.pass       = (state == DONE) && (err_q == '0);
  assign bus.err_count  = err_q;
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_index = fail_index_q;
endmodule

// File: tb/tb_ff_bist.sv
// tb/tb_ff_bist.sv - directed bench for ff_bist with an ideal/faulty flip-flop model
module tb_ff_bist;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] mode;
  logic q_ff;
  int total = 0;
  int bad = 0;

  ff_bist_if #(.ERR_W(8), .IW(5)) bus ();
  ff_bist_if #(.ERR_W(2), .IW(5)) sbus ();

  ff_bist #(.PATTERN_LEN(16), .PATTERN(16'hB4C3), .RST_CYCLES(2), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  ff_bist #(.PATTERN_LEN(16), .PATTERN(16'hB4C3), .RST_CYCLES(2), .ERR_W(2)) dut_small (
    .clk(clk), .reset(reset), .bus(sbus));

  always #5 clk = ~clk;

  // mode 0: ideal flop, 1: Q stuck-at-0, 2: Qbar follows Q
  always @(posedge clk) q_ff <= bus.dut_reset ? 1'b0 : bus.dut_d;
  assign bus.dut_q     = (mode == 2'd1) ? 1'b0 : q_ff;
  assign bus.dut_qbar  = (mode == 2'd2) ? bus.dut_q : ~bus.dut_q;
  assign sbus.dut_q    = bus.dut_q;
  assign sbus.dut_qbar = bus.dut_qbar;
  assign sbus.start    = bus.start;

  task automatic do_run(output int edges, output int busy_cyc, output int rst_cyc,
                        output logic [16:0] dseq);
    int j;
    edges = 0; busy_cyc = 0; rst_cyc = 0; dseq = '0; j = 0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; edges = 1;
    while (!bus.done && edges < 100) begin
      if (bus.busy) busy_cyc++;
      if (bus.busy && bus.dut_reset) rst_cyc++;
      if (bus.busy && !bus.dut_reset && j < 17) begin dseq[j] = bus.dut_d; j++; end
      @(negedge clk); edges++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b0; mode = 2'd0;
    repeat (3) @(negedge clk);
    total++; if (bus.dut_reset !== 1'b1) begin bad++; $display("FAIL reset_dut_reset got %b want 1", bus.dut_reset); end
    total++; if ({bus.dut_d, bus.busy, bus.done, bus.pass, bus.fail_valid} !== 5'b0) begin bad++;
      $display("FAIL reset_flags got %b want 00000", {bus.dut_d, bus.busy, bus.done, bus.pass, bus.fail_valid}); end
    total++; if (bus.err_count !== 8'd0 || bus.fail_index !== 5'd0) begin bad++;
      $display("FAIL reset_counts got err=%0d idx=%0d want 0 0", bus.err_count, bus.fail_index); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (bus.dut_reset !== 1'b0 || bus.busy !== 1'b0) begin bad++;
      $display("FAIL idle_outputs got dut_reset=%b busy=%b want 0 0", bus.dut_reset, bus.busy); end
  endtask

  task automatic test_ideal;
    int e, b, r; logic [16:0] s;
    mode = 2'd0;
    do_run(e, b, r, s);
    total++; if (e !== 20) begin bad++; $display("FAIL ideal_done_edge got %0d want 20", e); end
    total++; if (b !== 19) begin bad++; $display("FAIL ideal_busy_cycles got %0d want 19", b); end
    total++; if (r !== 2) begin bad++; $display("FAIL ideal_rst_cycles got %0d want 2", r); end
    total++; if (s !== 17'h0B4C3) begin bad++; $display("FAIL ideal_d_sequence got %h want 0b4c3", s); end
    total++; if (bus.err_count !== 8'd0 || bus.pass !== 1'b1 || bus.fail_valid !== 1'b0) begin bad++;
      $display("FAIL ideal_result got err=%0d pass=%b fv=%b want 0 1 0", bus.err_count, bus.pass, bus.fail_valid); end
    @(negedge clk);
    total++; if (bus.done !== 1'b1 || bus.dut_reset !== 1'b0 || bus.dut_d !== 1'b0) begin bad++;
      $display("FAIL done_hold got done=%b rst=%b d=%b want 1 0 0", bus.done, bus.dut_reset, bus.dut_d); end
  endtask

  task automatic test_stuck0;
    int e, b, r; logic [16:0] s;
    mode = 2'd1;
    do_run(e, b, r, s);
    total++; if (bus.err_count !== 8'd8) begin bad++; $display("FAIL stuck0_err got %0d want 8", bus.err_count); end
    total++; if (bus.fail_valid !== 1'b1 || bus.fail_index !== 5'd1) begin bad++;
      $display("FAIL stuck0_first got fv=%b idx=%0d want 1 1", bus.fail_valid, bus.fail_index); end
    total++; if (bus.pass !== 1'b0 || bus.done !== 1'b1) begin bad++;
      $display("FAIL stuck0_pass got pass=%b done=%b want 0 1", bus.pass, bus.done); end
  endtask

  task automatic test_qbar_eq_q;
    int e, b, r; logic [16:0] s;
    mode = 2'd2;
    do_run(e, b, r, s);
    total++; if (bus.err_count !== 8'd17) begin bad++; $display("FAIL qbar_err got %0d want 17", bus.err_count); end
    total++; if (bus.fail_index !== 5'd0 || bus.fail_valid !== 1'b1) begin bad++;
      $display("FAIL qbar_first got fv=%b idx=%0d want 1 0", bus.fail_valid, bus.fail_index); end
    total++; if (sbus.err_count !== 2'd3) begin bad++; $display("FAIL sat_err got %0d want 3", sbus.err_count); end
    total++; if (sbus.fail_index !== 5'd0 || sbus.pass !== 1'b0) begin bad++;
      $display("FAIL sat_first got idx=%0d pass=%b want 0 0", sbus.fail_index, sbus.pass); end
  endtask

  task automatic test_back_to_back;
    int e;
    mode = 2'd1;
    for (int run = 0; run < 2; run++) begin
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0; e = 1;
      total++; if (bus.done !== 1'b0 || bus.err_count !== 8'd0 || bus.busy !== 1'b1) begin bad++;
        $display("FAIL b2b_clear run%0d got done=%b err=%0d busy=%b want 0 0 1", run, bus.done, bus.err_count, bus.busy); end
      repeat (6) begin @(negedge clk); e++; end
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0; e++;
      while (!bus.done && e < 100) begin @(negedge clk); e++; end
      total++; if (e !== 20) begin bad++; $display("FAIL b2b_done_edge run%0d got %0d want 20", run, e); end
      total++; if (bus.err_count !== 8'd8 || bus.fail_index !== 5'd1) begin bad++;
        $display("FAIL b2b_result run%0d got err=%0d idx=%0d want 8 1", run, bus.err_count, bus.fail_index); end
    end
  endtask

  task automatic test_reset_mid_run;
    int e, b, r; logic [16:0] s;
    mode = 2'd2;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    repeat (7) @(negedge clk);
    total++; if (bus.err_count !== 8'd5) begin bad++; $display("FAIL mid_err_before got %0d want 5", bus.err_count); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.dut_reset !== 1'b1 || bus.busy !== 1'b0 || bus.err_count !== 8'd0 || bus.fail_valid !== 1'b0) begin bad++;
      $display("FAIL mid_reset got rst=%b busy=%b err=%0d fv=%b want 1 0 0 0", bus.dut_reset, bus.busy, bus.err_count, bus.fail_valid); end
    reset = 1'b0;
    mode = 2'd0;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.dut_reset !== 1'b0 || bus.done !== 1'b0) begin bad++;
      $display("FAIL mid_idle got busy=%b rst=%b done=%b want 0 0 0", bus.busy, bus.dut_reset, bus.done); end
    do_run(e, b, r, s);
    total++; if (e !== 20 || bus.pass !== 1'b1 || bus.err_count !== 8'd0) begin bad++;
      $display("FAIL mid_rerun got edge=%0d pass=%b err=%0d want 20 1 0", e, bus.pass, bus.err_count); end
  endtask

  initial begin
    test_reset;
    test_ideal;
    test_stuck0;
    test_qbar_eq_q;
    test_back_to_back;
    test_reset_mid_run;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
